pa_iu_ras_upd: RTL and testbench

Execute-stage resolver that drives the IFU return-address-stack update and redirect interface. It classifies resolved jumps and branches, compares predicted against actual outcome, and issues single-cycle, registered update pulses: link, return, PC-mispredict, BHT-mispredict, plus their clock-gate companions. It sits in the IU between EX decode/ALU results and the IFU, which keeps its RAS pointer in step with these pulses.

---
 rtl/pa_iu_ras_upd_pkg.sv | 19 +
 rtl/pa_iu_ras_upd_if.sv | 69 ++++++
 rtl/pa_iu_ras_upd_gated_clk_cell.sv | 36 +++
 rtl/pa_iu_ras_upd.sv | 155 +++++++++++++++
 tb/tb_pa_iu_ras_upd.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pa_iu_ras_upd_pkg.sv
// ---------------------------------------------------------------------------
// pa_iu_ras_upd_pkg
//   Shared IU definitions for the RAS update resolver: link-register indices,
//   default target-PC width and RAS depth, and the link-register test.
// ---------------------------------------------------------------------------
package pa_iu_ras_upd_pkg;

    localparam int PC_WIDTH_DEF  = 24;
    localparam int ENTRY_NUM_DEF = 4;

    // x1 (ra) and x5 (t0) are the RISC-V link registers.
    localparam logic [4:0] LINK_REG_X1 = 5'd1;
    localparam logic [4:0] LINK_REG_X5 = 5'd5;

    function automatic logic is_link_reg(input logic [4:0] idx);
        return (idx == LINK_REG_X1) || (idx == LINK_REG_X5);
    endfunction

endpackage

// File: rtl/pa_iu_ras_upd_if.sv
// ---------------------------------------------------------------------------
// pa_iu_ras_upd_if
//   EX-to-IFU RAS update bundle.
//   master : EX/RTU side, drives the resolved instruction and the flush,
//            observes the update pulses.
//   slave  : the resolver (pa_iu_ras_upd).
//
// Handshake: there is no ready. ex_inst_vld marks an instruction in EX and
// ex_stall holds it there; the resolver takes each instruction exactly once
// on its first valid cycle. The iu_ifu_* pulses are fire-and-forget: one
// cycle high, the IFU must act on them in that cycle. The *_gate outputs
// are a same-cycle-earlier superset used only for the IFU clock gates.
// ---------------------------------------------------------------------------
interface pa_iu_ras_upd_if
    import pa_iu_ras_upd_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int ENTRY_NUM = ENTRY_NUM_DEF
) ();

    localparam int DEPTH_W = $clog2(ENTRY_NUM + 1);

    // EX / RTU -> resolver
    logic                ex_inst_vld;
    logic                ex_stall;
    logic                ex_inst_jal;
    logic                ex_inst_jalr;
    logic                ex_inst_branch;
    logic [4:0]          ex_rd;
    logic [4:0]          ex_rs1;
    logic                ex_pred_taken;
    logic                ex_act_taken;
    logic [PC_WIDTH-1:0] ex_pred_tar_pc;
    logic [PC_WIDTH-1:0] ex_act_tar_pc;
    logic                rtu_ifu_flush_fe;

    // resolver -> IFU
    logic                iu_ifu_link_vld;
    logic                iu_ifu_ret_vld;
    logic                iu_ifu_pc_mispred;
    logic                iu_ifu_bht_mispred;
    logic                iu_ifu_link_vld_gate;
    logic                iu_ifu_ret_vld_gate;
    logic                iu_ifu_pc_mispred_gate;
    logic                iu_ifu_bht_mispred_gate;
    logic [DEPTH_W-1:0]  iu_ras_depth;
    logic                iu_ras_underflow;

    modport master (
        output ex_inst_vld, ex_stall, ex_inst_jal, ex_inst_jalr, ex_inst_branch,
               ex_rd, ex_rs1, ex_pred_taken, ex_act_taken,
               ex_pred_tar_pc, ex_act_tar_pc, rtu_ifu_flush_fe,
        input  iu_ifu_link_vld, iu_ifu_ret_vld, iu_ifu_pc_mispred, iu_ifu_bht_mispred,
               iu_ifu_link_vld_gate, iu_ifu_ret_vld_gate,
               iu_ifu_pc_mispred_gate, iu_ifu_bht_mispred_gate,
               iu_ras_depth, iu_ras_underflow
    );

    modport slave (
        input  ex_inst_vld, ex_stall, ex_inst_jal, ex_inst_jalr, ex_inst_branch,
               ex_rd, ex_rs1, ex_pred_taken, ex_act_taken,
               ex_pred_tar_pc, ex_act_tar_pc, rtu_ifu_flush_fe,
        output iu_ifu_link_vld, iu_ifu_ret_vld, iu_ifu_pc_mispred, iu_ifu_bht_mispred,
               iu_ifu_link_vld_gate, iu_ifu_ret_vld_gate,
               iu_ifu_pc_mispred_gate, iu_ifu_bht_mispred_gate,
               iu_ras_depth, iu_ras_underflow
    );

endinterface

// File: rtl/pa_iu_ras_upd_gated_clk_cell.sv
// ---------------------------------------------------------------------------
// pa_iu_ras_upd_gated_clk_cell
//   Latch-based integrated clock gate.
//   clk_in             : free-running clock
//   global_en          : chip-level clock enable
//   module_en          : forces the clock on (ICG disabled for this module)
//   local_en           : activity-based enable from the owning logic
//   external_en        : unconditional enable
//   pad_yy_icg_scan_en : scan mode, clock always on
//   clk_out            : gated clock
// ---------------------------------------------------------------------------
module pa_iu_ras_upd_gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_bf_latch;
    logic clk_en_lat;

    assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

    // Enable is captured while the clock is low so clk_out cannot glitch.
    always_latch begin
        if (!clk_in) begin
            clk_en_lat <= clk_en_bf_latch | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & clk_en_lat;

endmodule

// File: rtl/pa_iu_ras_upd.sv
// ---------------------------------------------------------------------------
// pa_iu_ras_upd
//   EX-stage resolver for the IFU return-address stack. Classifies the EX
//   instruction as call / return / jump / branch, compares predicted vs
//   resolved outcome and issues one-cycle registered pulses to the IFU.
//   Ports:
//     forever_cpuclk, cpurst_b     : clock, synchronous active-low reset
//     cp0_yy_clk_en, cp0_iu_icg_en,
//     pad_yy_icg_scan_en           : clock-gate controls
//     ras_if (slave)               : EX inputs, flush, IFU update pulses,
//                                    gate companions, depth and underflow
// ---------------------------------------------------------------------------
module pa_iu_ras_upd
    import pa_iu_ras_upd_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int ENTRY_NUM = ENTRY_NUM_DEF
) (
    input  logic           forever_cpuclk,
    input  logic           cpurst_b,
    input  logic           cp0_yy_clk_en,
    input  logic           cp0_iu_icg_en,
    input  logic           pad_yy_icg_scan_en,
    pa_iu_ras_upd_if.slave ras_if
);

    localparam int                 DEPTH_W   = $clog2(ENTRY_NUM + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(ENTRY_NUM);

    logic                ras_clk;
    logic                local_en;

    logic [PC_WIDTH-1:0] pred_pc;
    logic [PC_WIDTH-1:0] act_pc;
    logic                rd_link;
    logic                rs1_link;
    logic                is_jump;
    logic                is_call;
    logic                is_ret;
    logic                is_pc_mis;
    logic                is_bht_mis;
    logic                fire;
    logic                flush;

    logic                fire_done_q;
    logic                link_q;
    logic                ret_q;
    logic                pc_mis_q;
    logic                bht_mis_q;
    logic [DEPTH_W-1:0]  depth_q;

    logic                link_out;
    logic                ret_out;

    //------------------------------------------------------------------
    // Classification and compare
    //------------------------------------------------------------------
    assign pred_pc  = ras_if.ex_pred_tar_pc;
    assign act_pc   = ras_if.ex_act_tar_pc;
    assign flush    = ras_if.rtu_ifu_flush_fe;

    assign rd_link  = is_link_reg(ras_if.ex_rd);
    assign rs1_link = is_link_reg(ras_if.ex_rs1);
    assign is_jump  = ras_if.ex_inst_jal | ras_if.ex_inst_jalr;

    // A jalr that both writes and reads a link register is treated purely
    // as a call; the return half is dropped.
    assign is_call    = is_jump & rd_link;
    assign is_ret     = ras_if.ex_inst_jalr & rs1_link & ~rd_link;
    assign is_pc_mis  = is_jump & (pred_pc != act_pc);
    assign is_bht_mis = ras_if.ex_inst_branch
                      & (ras_if.ex_pred_taken != ras_if.ex_act_taken);

    // Only the first EX cycle of an instruction may fire.
    assign fire = ras_if.ex_inst_vld & ~fire_done_q;

    //------------------------------------------------------------------
    // Clock gate. Reset and a pending fire_done also keep the clock
    // running so both can be cleared without an instruction present.
    //------------------------------------------------------------------
    assign local_en = ras_if.ex_inst_vld | flush
                    | link_q | ret_q | pc_mis_q | bht_mis_q
                    | fire_done_q | ~cpurst_b;

    pa_iu_ras_upd_gated_clk_cell x_gated_clk_cell (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_iu_icg_en),
        .local_en           (local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (ras_clk)
    );

    //------------------------------------------------------------------
    // fire_done: remembers that a stalled instruction already fired.
    //------------------------------------------------------------------
    always_ff @(posedge ras_clk) begin
        if (!cpurst_b) begin
            fire_done_q <= 1'b0;
        end else if (flush || !ras_if.ex_stall) begin
            fire_done_q <= 1'b0;
        end else if (fire) begin
            fire_done_q <= 1'b1;
        end
    end

    //------------------------------------------------------------------
    // Registered update pulses
    //------------------------------------------------------------------
    always_ff @(posedge ras_clk) begin
        if (!cpurst_b) begin
            link_q    <= 1'b0;
            ret_q     <= 1'b0;
            pc_mis_q  <= 1'b0;
            bht_mis_q <= 1'b0;
        end else begin
            link_q    <= is_call    & fire & ~flush;
            ret_q     <= is_ret     & fire & ~flush;
            pc_mis_q  <= is_pc_mis  & fire & ~flush;
            bht_mis_q <= is_bht_mis & fire & ~flush;
        end
    end

    // A flush in the output cycle also kills a pulse already registered.
    assign link_out                  = link_q & ~flush;
    assign ret_out                   = ret_q  & ~flush;
    assign ras_if.iu_ifu_link_vld    = link_out;
    assign ras_if.iu_ifu_ret_vld     = ret_out;
    assign ras_if.iu_ifu_pc_mispred  = pc_mis_q  & ~flush;
    assign ras_if.iu_ifu_bht_mispred = bht_mis_q & ~flush;

    // Gate companions: no fire/flush qualification, one cycle ahead.
    assign ras_if.iu_ifu_link_vld_gate    = is_call    & ras_if.ex_inst_vld;
    assign ras_if.iu_ifu_ret_vld_gate     = is_ret     & ras_if.ex_inst_vld;
    assign ras_if.iu_ifu_pc_mispred_gate  = is_pc_mis  & ras_if.ex_inst_vld;
    assign ras_if.iu_ifu_bht_mispred_gate = is_bht_mis & ras_if.ex_inst_vld;

    //------------------------------------------------------------------
    // Committed depth: follows the pulses the IFU actually sees.
    //------------------------------------------------------------------
    always_ff @(posedge ras_clk) begin
        if (!cpurst_b) begin
            depth_q <= '0;
        end else if (link_out && (depth_q != DEPTH_MAX)) begin
            depth_q <= depth_q + DEPTH_W'(1);
        end else if (ret_out && (depth_q != '0)) begin
            depth_q <= depth_q - DEPTH_W'(1);
        end
    end

    assign ras_if.iu_ras_depth     = depth_q;
    assign ras_if.iu_ras_underflow = ret_out & (depth_q == '0);

endmodule

// File: tb/tb_pa_iu_ras_upd.sv
// ---------------------------------------------------------------------------
// tb_pa_iu_ras_upd
//   Directed bench for the RAS update resolver. Inputs change 1 time unit
//   after the rising edge, outputs are sampled on the falling edge.
//   Pulse vectors are packed {link, ret, pc_mispred, bht_mispred}.
// ---------------------------------------------------------------------------
module tb_pa_iu_ras_upd;

    import pa_iu_ras_upd_pkg::*;

    localparam int PC_W = 24;
    localparam int ENT  = 4;

    localparam logic [3:0] P_L = 4'b1000;
    localparam logic [3:0] P_R = 4'b0100;
    localparam logic [3:0] P_P = 4'b0010;
    localparam logic [3:0] P_B = 4'b0001;
    localparam logic [3:0] P_0 = 4'b0000;

    logic forever_cpuclk;
    logic cpurst_b;
    logic cp0_yy_clk_en;
    logic cp0_iu_icg_en;
    logic pad_yy_icg_scan_en;

    int checks = 0;
    int errors = 0;

    pa_iu_ras_upd_if #(.PC_WIDTH(PC_W), .ENTRY_NUM(ENT)) ras_if ();

    pa_iu_ras_upd #(.PC_WIDTH(PC_W), .ENTRY_NUM(ENT)) u_dut (
        .forever_cpuclk     (forever_cpuclk),
        .cpurst_b           (cpurst_b),
        .cp0_yy_clk_en      (cp0_yy_clk_en),
        .cp0_iu_icg_en      (cp0_iu_icg_en),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .ras_if             (ras_if)
    );

    //------------------------------------------------------------------
    // Clock
    //------------------------------------------------------------------
    initial begin
        forever_cpuclk = 1'b0;
        forever #5 forever_cpuclk = ~forever_cpuclk;
    end

    //------------------------------------------------------------------
    // Checking
    //------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_pulse(input string tag, input logic [3:0] exp);
        chk(tag, 32'({ras_if.iu_ifu_link_vld, ras_if.iu_ifu_ret_vld,
                      ras_if.iu_ifu_pc_mispred, ras_if.iu_ifu_bht_mispred}), 32'(exp));
    endtask

    task automatic chk_gate(input string tag, input logic [3:0] exp);
        chk(tag, 32'({ras_if.iu_ifu_link_vld_gate, ras_if.iu_ifu_ret_vld_gate,
                      ras_if.iu_ifu_pc_mispred_gate, ras_if.iu_ifu_bht_mispred_gate}), 32'(exp));
    endtask

    task automatic chk_depth(input string tag, input int exp);
        chk(tag, 32'(ras_if.iu_ras_depth), 32'(exp));
    endtask

    task automatic chk_uflow(input string tag, input logic exp);
        chk(tag, 32'(ras_if.iu_ras_underflow), 32'(exp));
    endtask

    //------------------------------------------------------------------
    // Drivers
    //------------------------------------------------------------------
    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic mid();
        @(negedge forever_cpuclk);
    endtask

    task automatic drive_idle();
        ras_if.ex_inst_vld      = 1'b0;
        ras_if.ex_stall         = 1'b0;
        ras_if.ex_inst_jal      = 1'b0;
        ras_if.ex_inst_jalr     = 1'b0;
        ras_if.ex_inst_branch   = 1'b0;
        ras_if.ex_rd            = 5'd0;
        ras_if.ex_rs1           = 5'd0;
        ras_if.ex_pred_taken    = 1'b0;
        ras_if.ex_act_taken     = 1'b0;
        ras_if.ex_pred_tar_pc   = '0;
        ras_if.ex_act_tar_pc    = '0;
        ras_if.rtu_ifu_flush_fe = 1'b0;
    endtask

    task automatic drive_inst(input logic jal, input logic jalr, input logic br,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic pt, input logic at,
                              input logic [PC_W-1:0] ppc, input logic [PC_W-1:0] apc);
        ras_if.ex_inst_vld      = 1'b1;
        ras_if.ex_stall         = 1'b0;
        ras_if.ex_inst_jal      = jal;
        ras_if.ex_inst_jalr     = jalr;
        ras_if.ex_inst_branch   = br;
        ras_if.ex_rd            = rd;
        ras_if.ex_rs1           = rs1;
        ras_if.ex_pred_taken    = pt;
        ras_if.ex_act_taken     = at;
        ras_if.ex_pred_tar_pc   = ppc;
        ras_if.ex_act_tar_pc    = apc;
        ras_if.rtu_ifu_flush_fe = 1'b0;
    endtask

    //------------------------------------------------------------------
    // Stimulus
    //------------------------------------------------------------------
    initial begin
        cp0_yy_clk_en      = 1'b1;
        cp0_iu_icg_en      = 1'b0;
        pad_yy_icg_scan_en = 1'b0;
        cpurst_b           = 1'b0;
        drive_idle();
        repeat (3) tick();

        // Reset state
        mid();
        chk_pulse("rst_pulse", P_0);
        chk_gate("rst_gate", P_0);
        chk_depth("rst_depth", 0);
        chk_uflow("rst_uflow", 1'b0);
        tick();
        cpurst_b = 1'b1;
        tick();

        // Call: jal x1
        drive_inst(1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 24'h000100, 24'h000100);
        mid();
        chk_gate("call_gate", P_L);
        chk_pulse("call_pre", P_0);
        tick();
        drive_idle();
        mid();
        chk_pulse("call_pulse", P_L);
        chk_depth("call_depth_pre", 0);
        tick();
        mid();
        chk_pulse("call_once", P_0);
        chk_depth("call_depth", 1);
        tick();

        // Return: jalr rd=0 rs1=x1
        drive_inst(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 24'h000100, 24'h000100);
        mid();
        chk_gate("ret_gate", P_R);
        tick();
        drive_idle();
        mid();
        chk_pulse("ret_pulse", P_R);
        chk_uflow("ret_uflow", 1'b0);
        tick();
        mid();
        chk_depth("ret_depth", 0);
        tick();

        // Mispredicted return (at depth 0, so it also underflows)
        drive_inst(1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 1'b0, 1'b0, 24'h000200, 24'h000204);
        mid();
        chk_gate("mret_gate", P_R | P_P);
        chk_pulse("mret_pre", P_0);
        tick();
        drive_idle();
        mid();
        chk_pulse("mret_pulse", P_R | P_P);
        chk_uflow("mret_uflow", 1'b1);
        tick();
        mid();
        chk_pulse("mret_once", P_0);
        chk_depth("mret_depth", 0);
        tick();

        // Stall: jal x1 held 5 stalled cycles then one unstalled cycle
        for (int i = 0; i < 6; i++) begin
            drive_inst(1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 24'h000300, 24'h000300);
            ras_if.ex_stall = (i < 5);
            mid();
            chk_pulse($sformatf("stall_c%0d", i), (i == 1) ? P_L : P_0);
            tick();
        end
        drive_idle();
        mid();
        chk_pulse("stall_end", P_0);
        chk_depth("stall_depth", 1);
        tick();

        // Flush in the same cycle as a mispredicted branch
        drive_inst(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, '0, '0);
        ras_if.rtu_ifu_flush_fe = 1'b1;
        mid();
        chk_gate("fl_same_gate", P_B);
        tick();
        drive_idle();
        mid();
        chk_pulse("fl_same_pulse", P_0);
        tick();

        // Flush in the output cycle
        drive_inst(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, '0, '0);
        mid();
        chk_gate("fl_out_gate", P_B);
        tick();
        drive_idle();
        ras_if.rtu_ifu_flush_fe = 1'b1;
        mid();
        chk_pulse("fl_out_pulse", P_0);
        tick();
        ras_if.rtu_ifu_flush_fe = 1'b0;
        mid();
        chk_pulse("fl_out_after", P_0);
        tick();

        // Unflushed branch mispredict, then a correctly predicted branch
        drive_inst(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, '0, '0);
        mid();
        chk_gate("bht_gate", P_B);
        tick();
        drive_inst(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, '0, '0);
        mid();
        chk_pulse("bht_pulse", P_B);
        chk_gate("bht_ok_gate", P_0);
        tick();
        drive_idle();
        mid();
        chk_pulse("bht_ok_pulse", P_0);
        tick();

        // Bring depth from 1 back to 0
        drive_inst(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, '0, '0);
        tick();
        drive_idle();
        mid();
        chk_uflow("pre_sat_uflow", 1'b0);
        tick();
        mid();
        chk_depth("pre_sat_depth", 0);
        tick();

        // 5 back-to-back calls: one pulse per cycle, depth saturates at 4
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive_inst(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b0, '0, '0);
            else       drive_idle();
            mid();
            chk_pulse($sformatf("sat_pulse_c%0d", i), (i > 0) ? P_L : P_0);
            chk_depth($sformatf("sat_depth_c%0d", i), (i > 0) ? i - 1 : 0);
            tick();
        end
        mid();
        chk_depth("sat_depth", 4);
        tick();

        // 5 back-to-back returns: depth to 0, underflow only on the 5th
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive_inst(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, '0, '0);
            else       drive_idle();
            mid();
            chk_pulse($sformatf("uf_pulse_c%0d", i), (i > 0) ? P_R : P_0);
            chk_depth($sformatf("uf_depth_c%0d", i), (i == 0) ? 4 : 5 - i);
            chk_uflow($sformatf("uf_flag_c%0d", i), i == 5);
            tick();
        end
        mid();
        chk_depth("uf_depth", 0);
        chk_uflow("uf_after", 1'b0);
        tick();

        // jalr rd=x1 rs1=x5: call only
        drive_inst(1'b0, 1'b1, 1'b0, 5'd1, 5'd5, 1'b0, 1'b0, 24'h000400, 24'h000400);
        mid();
        chk_gate("both_gate", P_L);
        tick();
        drive_idle();
        mid();
        chk_pulse("both_pulse", P_L);
        tick();
        mid();
        chk_depth("both_depth", 1);
        tick();

        // Reset asserted mid-stall
        drive_inst(1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, '0, '0);
        ras_if.ex_stall = 1'b1;
        mid();
        chk_pulse("rs_a", P_0);
        tick();
        cpurst_b = 1'b0;
        mid();
        chk_pulse("rs_b", P_L);
        tick();
        cpurst_b = 1'b1;
        mid();
        chk_pulse("rs_c_pulse", P_0);
        chk_depth("rs_c_depth", 0);
        chk_uflow("rs_c_uflow", 1'b0);
        chk_gate("rs_c_gate", P_L);
        tick();
        mid();
        chk_pulse("rs_d_refire", P_L);
        tick();
        ras_if.ex_stall = 1'b0;
        mid();
        chk_pulse("rs_e_pulse", P_0);
        chk_depth("rs_e_depth", 1);
        tick();
        drive_idle();
        mid();
        chk_pulse("rs_f_pulse", P_0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus never reaches its summary.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
